// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared widths, FSM states and unpacked-operand type for fp_addsub_seq
package fp_pkg;
  localparam int EXP_W   = 5;
  localparam int MAN_W   = 10;
  localparam int BIAS    = 2**(EXP_W-1)-1;
  localparam int EXP_MAX = 2**EXP_W-1;
  localparam int FW      = 1+EXP_W+MAN_W;

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
  } fp_state_e;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   man_ext;
  } fp_unpacked_t;

  // exp==0 is treated as zero; the stored fraction is then ignored
  function automatic fp_unpacked_t fp_unpack(input logic [FW-1:0] v);
    fp_unpacked_t u;
    u.sign    = v[FW-1];
    u.exp     = v[FW-2:MAN_W];
    u.man_ext = (u.exp == '0) ? '0 : {1'b1, v[MAN_W-1:0]};
    return u;
  endfunction
endpackage

// File: rtl/fp_addsub_seq_if.sv
// rtl/fp_addsub_seq_if.sv - operand/result handshake bundle between the program FSM and the adder
interface fp_addsub_seq_if;
  import fp_pkg::*;
  logic          start;
  logic          op_i;
  logic [FW-1:0] a_i;
  logic [FW-1:0] b_i;
  logic [FW-1:0] result;
  logic          done;
  logic          ovf;
  logic          zero;

  modport master (output start, op_i, a_i, b_i, input result, done, ovf, zero);
  modport slave  (input start, op_i, a_i, b_i, output result, done, ovf, zero);
endinterface

// File: rtl/fp_norm_step.sv
// rtl/fp_norm_step.sv - one normalisation step: right shift on carry or left shift pulling in G
module fp_norm_step #(
  parameter int MW = 12,
  parameter int EW = 6
) (
  input  logic [MW-1:0] i_man,
  input  logic [EW-1:0] i_exp,
  input  logic          i_g,
  input  logic          i_r,
  input  logic          i_s,
  input  logic          i_left,
  output logic [MW-1:0] o_man,
  output logic [EW-1:0] o_exp,
  output logic          o_g,
  output logic          o_r,
  output logic          o_s
);
  always_comb begin
    if (i_left) begin
      o_man = {i_man[MW-2:0], i_g};
      o_exp = i_exp - 1'b1;
      o_g   = i_r;
      o_r   = i_s;
      o_s   = i_s;
    end else begin
      o_man = {1'b0, i_man[MW-1:1]};
      o_exp = i_exp + 1'b1;
      o_g   = i_man[0];
      o_r   = i_g;
      o_s   = i_s | i_r;
    end
  end
endmodule

// File: rtl/fp_addsub_seq.sv
// rtl/fp_addsub_seq.sv - multi-cycle float add/subtract with GRS alignment and bidirectional normalise
// FP_ROUND_EN selects round-to-nearest-even; otherwise the ROUND state truncates.
module fp_addsub_seq
  import fp_pkg::*;
(
  input logic            clk,
  input logic            reset,
  fp_addsub_seq_if.slave bus
);
  localparam int SW = MAN_W + 5;
  localparam logic [EXP_W-1:0] ALIGN_LIM = EXP_W'(MAN_W + 3);
  localparam logic [EXP_W:0]   EXP_TOP   = (EXP_W+1)'(EXP_MAX);

  fp_state_e      r_state;
  logic [FW-1:0]  r_a, r_b;
  fp_unpacked_t   r_x, r_y;
  logic           r_y_zero;
  logic [MAN_W+1:0] r_man;
  logic [EXP_W:0] r_exp;
  logic           r_sign, r_g, r_r, r_s;
  logic [FW-1:0]  r_result;
  logic           r_done, r_ovf, r_zero;

  fp_unpacked_t     w_ua, w_ub, w_x, w_y;
  logic             w_a_big;
  logic [EXP_W-1:0] w_udiff, w_diff;
  logic [SW-1:0]    w_xe, w_ye, w_sum;
  logic [MAN_W+1:0] w_n_man;
  logic [EXP_W:0]   w_n_exp;
  logic             w_n_g, w_n_r, w_n_s, w_inc, w_ovf;
  logic [MAN_W:0]   w_rnd;
  logic [EXP_W:0]   w_rexp;

  assign w_ua    = fp_unpack(r_a);
  assign w_ub    = fp_unpack(r_b);
  assign w_a_big = {w_ua.exp, w_ua.man_ext} >= {w_ub.exp, w_ub.man_ext};
  assign w_x     = w_a_big ? w_ua : w_ub;
  assign w_y     = w_a_big ? w_ub : w_ua;
  assign w_udiff = w_x.exp - w_y.exp;
  // r_y.exp climbs toward r_x.exp during ALIGN, so the difference is the shift counter
  assign w_diff  = r_x.exp - r_y.exp;

  assign w_xe  = {1'b0, r_x.man_ext, 3'b000};
  assign w_ye  = {1'b0, r_y.man_ext, r_g, r_r, r_s};
  assign w_sum = (r_x.sign ^ r_y.sign) ? (w_xe - w_ye) : (w_xe + w_ye);

  fp_norm_step #(.MW(MAN_W+2), .EW(EXP_W+1)) u_norm (
    .i_man (r_man),   .i_exp (r_exp),   .i_g (r_g),   .i_r (r_r),   .i_s (r_s),
    .i_left(!r_man[MAN_W+1]),
    .o_man (w_n_man), .o_exp (w_n_exp), .o_g (w_n_g), .o_r (w_n_r), .o_s (w_n_s)
  );

`ifdef FP_ROUND_EN
  assign w_inc = r_g & (r_r | r_s | r_man[0]);
`else
  assign w_inc = 1'b0;
`endif
  // a carry out of the fraction means the mantissa became 10.0...0
  assign w_rnd  = {1'b0, r_man[MAN_W-1:0]} + {{MAN_W{1'b0}}, w_inc};
  assign w_rexp = r_exp + {{EXP_W{1'b0}}, w_rnd[MAN_W]};
  assign w_ovf  = w_rexp >= EXP_TOP;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_y_zero <= 1'b0;
      r_man    <= '0;
      r_exp    <= '0;
      r_sign   <= 1'b0;
      r_g      <= 1'b0;
      r_r      <= 1'b0;
      r_s      <= 1'b0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_a     <= bus.a_i;
            r_b     <= {bus.b_i[FW-1] ^ bus.op_i, bus.b_i[FW-2:0]};
            r_done  <= 1'b0;
            r_state <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          r_x      <= w_x;
          r_y      <= w_y;
          r_y_zero <= (w_y.exp == '0);
          r_g      <= 1'b0;
          r_r      <= 1'b0;
          r_s      <= 1'b0;
          r_state  <= (w_y.exp == '0 || w_udiff == '0) ? S_ADD : S_ALIGN;
        end
        S_ALIGN: begin
          if (w_diff > ALIGN_LIM) begin
            r_y.man_ext <= '0;
            r_y.exp     <= r_x.exp;
            r_g         <= 1'b0;
            r_r         <= 1'b0;
            r_s         <= |r_y.man_ext;
            r_state     <= S_ADD;
          end else begin
            r_y.man_ext <= r_y.man_ext >> 1;
            r_y.exp     <= r_y.exp + 1'b1;
            r_g         <= r_y.man_ext[0];
            r_r         <= r_g;
            r_s         <= r_s | r_r;
            if (w_diff == EXP_W'(1)) r_state <= S_ADD;
          end
        end
        S_ADD: begin
          r_man             <= w_sum[SW-1:3];
          {r_g, r_r, r_s}   <= w_sum[2:0];
          r_exp             <= {1'b0, r_x.exp};
          r_sign            <= r_x.sign;
          if (w_sum == '0) begin
            r_result <= '0;
            r_zero   <= 1'b1;
            r_ovf    <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_state <= r_y_zero ? S_ROUND : S_NORM;
          end
        end
        S_NORM: begin
          if (r_man[MAN_W+1] || !r_man[MAN_W]) begin
            if (!r_man[MAN_W+1] && w_n_exp == '0) begin
              r_result <= '0;
              r_zero   <= 1'b1;
              r_ovf    <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_man <= w_n_man;
              r_exp <= w_n_exp;
              r_g   <= w_n_g;
              r_r   <= w_n_r;
              r_s   <= w_n_s;
            end
          end else begin
            r_state <= S_ROUND;
          end
        end
        S_ROUND: begin
          if (w_ovf) r_result <= {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          else       r_result <= {r_sign, w_rexp[EXP_W-1:0], w_rnd[MAN_W-1:0]};
          r_ovf   <= w_ovf;
          r_zero  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.result = r_result;
  assign bus.done   = r_done;
  assign bus.ovf    = r_ovf;
  assign bus.zero   = r_zero;
endmodule

// File: tb/tb_fp_addsub_seq.sv
// tb/tb_fp_addsub_seq.sv - directed-vector bench for fp_addsub_seq (half-precision widths)
module tb_fp_addsub_seq;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

`ifdef FP_ROUND_EN
  localparam logic [15:0] TIE_ODD_RES = 16'h3C02;
`else
  localparam logic [15:0] TIE_ODD_RES = 16'h3C01;
`endif

  fp_addsub_seq_if bus();
  fp_addsub_seq dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic op);
    @(negedge clk);
    bus.a_i   = a;
    bus.b_i   = b;
    bus.op_i  = op;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (bus.done !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_case(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic op, input logic [15:0] exp_res, input logic exp_ovf,
                          input logic exp_zero, input int exp_lat);
    int lat;
    issue(a, b, op);
    wait_done(lat);
    check_eq({tag, "_done"}, 32'(bus.done),   32'd1);
    check_eq({tag, "_res"},  32'(bus.result), 32'(exp_res));
    check_eq({tag, "_ovf"},  32'(bus.ovf),    32'(exp_ovf));
    check_eq({tag, "_zero"}, 32'(bus.zero),   32'(exp_zero));
    check_eq({tag, "_lat"},  32'(lat),        32'(exp_lat));
  endtask

  initial begin
    int lat;
    bus.start = 1'b0;
    bus.op_i  = 1'b0;
    bus.a_i   = '0;
    bus.b_i   = '0;
    reset     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_done", 32'(bus.done),   32'd0);
    check_eq("rst_res",  32'(bus.result), 32'd0);
    check_eq("rst_ovf",  32'(bus.ovf),    32'd0);
    check_eq("rst_zero", 32'(bus.zero),   32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_case("one_plus_one", 16'h3C00, 16'h3C00, 1'b0, 16'h4000, 1'b0, 1'b0, 6);
    run_case("add_1p5_2p5",  16'h3E00, 16'h4100, 1'b0, 16'h4400, 1'b0, 1'b0, 7);
    run_case("sub_2_1",      16'h4000, 16'h3C00, 1'b1, 16'h3C00, 1'b0, 1'b0, 7);
    run_case("sub_cancel",   16'h3C00, 16'h3C00, 1'b1, 16'h0000, 1'b0, 1'b1, 3);
    run_case("tie_odd",      16'h3C01, 16'h1000, 1'b0, TIE_ODD_RES, 1'b0, 1'b0, 16);
    run_case("tie_even",     16'h3C00, 16'h1000, 1'b0, 16'h3C00, 1'b0, 1'b0, 16);
    run_case("overflow",     16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 1'b1, 1'b0, 6);
    run_case("b_zero",       16'h3C00, 16'h0000, 1'b0, 16'h3C00, 1'b0, 1'b0, 4);
    run_case("a_zero_sub",   16'h0000, 16'h3C00, 1'b1, 16'hBC00, 1'b0, 1'b0, 4);
    run_case("neg_sum",      16'hC000, 16'h3C00, 1'b0, 16'hBC00, 1'b0, 1'b0, 7);

    repeat (4) @(posedge clk);
    #1;
    check_eq("hold_done", 32'(bus.done),   32'd1);
    check_eq("hold_res",  32'(bus.result), 32'h0000BC00);

    run_case("collapse",     16'h3C00, 16'h0400, 1'b0, 16'h3C00, 1'b0, 1'b0, 6);

    // abort during ALIGN: nothing of the aborted operation or the previous result may survive
    issue(16'h3E00, 16'h4100, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    #2;
    check_eq("abort_done", 32'(bus.done),   32'd0);
    check_eq("abort_res",  32'(bus.result), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_case("restart",      16'h3E00, 16'h4100, 1'b0, 16'h4400, 1'b0, 1'b0, 7);

    issue(16'h3E00, 16'h4100, 1'b0);
    @(negedge clk);
    bus.a_i   = 16'h7BFF;
    bus.b_i   = 16'h7BFF;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(lat);
    check_eq("busy_start_res", 32'(bus.result), 32'h00004400);
    check_eq("busy_start_ovf", 32'(bus.ovf),    32'd0);

    run_case("flush",        16'h0C00, 16'h0BFF, 1'b1, 16'h0000, 1'b0, 1'b1, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
